// File: rtl/rom_access_arbiter.sv
// Purpose: round-robin arbiter sharing one program ROM between port A (fetch) and port B (debug).
// Latency: grant edge + WAIT_STATES + 1 edges to the ack cycle; one access every 3 + WAIT_STATES cycles.
// Backpressure: requests are levels held until ack; requesters simply wait while the other port is served.
//
// Ports:
//   clk, low_rst             clock, async active-low reset
//   req_a/addr_a/ack_a       port A request level, address, one-cycle ack pulse
//   req_b/addr_b/ack_b       port B request level, address, one-cycle ack pulse
//   data_out                 latched ROM data, valid in the ack cycle, held until next capture
//   busy                     high whenever a transaction is in flight
//   rom_addr/rom_low_o_en    ROM address and active-low output enable (sole driver)
//   rom_data                 ROM read data
module rom_access_arbiter #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              low_rst,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_low_o_en,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int               CNT_W     = 3;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             last_b;     // port served most recently (1 = B)
    logic             serving_b;  // port owning the current transaction
    logic             grant_b;

    // B wins when it is the only requester, or when both request and A was served last.
    assign grant_b = req_b & (~req_a | ~last_b);

    always_ff @(posedge clk or negedge low_rst) begin
        if (!low_rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            last_b       <= 1'b1;   // A takes the first tie after reset
            serving_b    <= 1'b0;
            ack_a        <= 1'b0;
            ack_b        <= 1'b0;
            data_out     <= '0;
            busy         <= 1'b0;
            rom_addr     <= '0;
            rom_low_o_en <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        serving_b    <= grant_b;
                        last_b       <= grant_b;
                        rom_addr     <= grant_b ? addr_b : addr_a;
                        rom_low_o_en <= 1'b0;
                        wait_cnt     <= WAIT_INIT;
                        busy         <= 1'b1;
                        state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        // Capture and release the ROM; rom_addr is left as is.
                        data_out     <= rom_data;
                        ack_a        <= ~serving_b;
                        ack_b        <= serving_b;
                        rom_low_o_en <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // Requests are deliberately not sampled here, giving the
                    // requester this cycle to change its address.
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
module tb_rom_access_arbiter;

    logic       clk = 1'b0;
    logic       low_rst;
    logic       req_a   [2];
    logic       req_b   [2];
    logic [3:0] addr_a  [2];
    logic [3:0] addr_b  [2];
    logic       ack_a   [2];
    logic       ack_b   [2];
    logic [7:0] data_out[2];
    logic       busy    [2];
    logic [3:0] rom_addr[2];
    logic       rom_en_n[2];
    logic [7:0] rom_data[2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [3:0] a);
        return {a, ~a};
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Behavioural ROMs
    assign rom_data[0] = rom_fn(rom_addr[0]);
    assign rom_data[1] = rom_fn(rom_addr[1]);

    rom_access_arbiter #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .low_rst(low_rst),
        .req_a(req_a[0]), .addr_a(addr_a[0]), .ack_a(ack_a[0]),
        .req_b(req_b[0]), .addr_b(addr_b[0]), .ack_b(ack_b[0]),
        .data_out(data_out[0]), .busy(busy[0]),
        .rom_addr(rom_addr[0]), .rom_low_o_en(rom_en_n[0]), .rom_data(rom_data[0])
    );

    rom_access_arbiter #(.ADDR_W(4), .DATA_W(8), .WAIT_STATES(3)) dut3 (
        .clk(clk), .low_rst(low_rst),
        .req_a(req_a[1]), .addr_a(addr_a[1]), .ack_a(ack_a[1]),
        .req_b(req_b[1]), .addr_b(addr_b[1]), .ack_b(ack_b[1]),
        .data_out(data_out[1]), .busy(busy[1]),
        .rom_addr(rom_addr[1]), .rom_low_o_en(rom_en_n[1]), .rom_data(rom_data[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-timeline model: a grant at edge g makes the ROM enabled
    // after edges g..g+WS, the ack/capture after edge g+WS+1, idle after g+WS+2.
    int         cyc;
    bit         m_txn   [2];
    int         m_g     [2];
    bit         m_win_b [2];
    bit         m_last_b[2];
    logic [3:0] m_addr  [2];
    logic [7:0] m_data  [2];

    always @(posedge clk or negedge low_rst) begin
        if (!low_rst) begin
            cyc = 0;
            for (int d = 0; d < 2; d++) begin
                m_txn[d] = 0; m_g[d] = 0; m_win_b[d] = 0; m_last_b[d] = 1;
                m_addr[d] = 4'h0; m_data[d] = 8'h00;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (m_txn[d]) begin
                    if (cyc - m_g[d] == ws(d) + 2) m_txn[d] = 0;
                    else if (cyc - m_g[d] == ws(d) + 1) m_data[d] = rom_fn(m_addr[d]);
                end else if (req_a[d] || req_b[d]) begin
                    m_win_b[d]  = req_b[d] && (!req_a[d] || !m_last_b[d]);
                    m_last_b[d] = m_win_b[d];
                    m_addr[d]   = m_win_b[d] ? addr_b[d] : addr_a[d];
                    m_g[d]      = cyc;
                    m_txn[d]    = 1;
                end
            end
        end
    end

    // Compare process: every negedge, both DUTs against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   age;
            logic e_ack, e_en_low;
            logic [15:0] exp_v, act_v;
            age      = cyc - m_g[d];
            e_ack    = m_txn[d] && (age == ws(d) + 1);
            e_en_low = m_txn[d] && (age <= ws(d));
            exp_v = {e_ack && !m_win_b[d], e_ack && m_win_b[d], m_txn[d] ? 1'b1 : 1'b0,
                     ~e_en_low, m_addr[d], m_data[d]};
            act_v = {ack_a[d], ack_b[d], busy[d], rom_en_n[d], rom_addr[d], data_out[d]};
            chk($sformatf("model_cmp_dut%0d", d), 32'(act_v), 32'(exp_v));
            if (ack_a[d] && ack_b[d]) chk($sformatf("ack_exclusive_dut%0d", d), 1, 0);
            if (!low_rst && (ack_a[d] || ack_b[d])) chk($sformatf("ack_in_reset_dut%0d", d), 1, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int d = 0; d < 2; d++) begin
            req_a[d] = 0; req_b[d] = 0; addr_a[d] = 4'h0; addr_b[d] = 4'h0;
        end
    endtask

    task automatic pulse_reset();
        low_rst = 0;
        step();
        step();
        low_rst = 1;
    endtask

    initial begin
        int first_en, ack_at, en_cnt, n_ack, last_ack, idx;
        bit exp_b;
        logic [7:0] got;

        clear_reqs();
        low_rst = 0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk("reset_outputs", {ack_a[d], ack_b[d], busy[d], rom_en_n[d], rom_addr[d], data_out[d]},
                {1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00});
        end
        low_rst = 1;
        step();

        // Single A read, no wait states.
        req_a[0] = 1; addr_a[0] = 4'd3;
        step();
        chk("single_drive_en", rom_en_n[0], 0);
        chk("single_drive_addr", rom_addr[0], 3);
        step();
        chk("single_ack_a", ack_a[0], 1);
        chk("single_data", data_out[0], 8'h3C);
        req_a[0] = 0;
        step();
        chk("single_ack_drop", ack_a[0], 0);
        chk("single_busy_drop", busy[0], 0);

        // Contention: alternation A,B,... one ack every 3 cycles.
        pulse_reset();
        req_a[0] = 1; addr_a[0] = 4'd1; req_b[0] = 1; addr_b[0] = 4'd14;
        n_ack = 0; last_ack = 0; exp_b = 0;
        for (int i = 0; i < 40 && n_ack < 6; i++) begin
            step();
            if (ack_a[0] || ack_b[0]) begin
                chk("contend_port", ack_b[0], exp_b);
                chk("contend_data", data_out[0], exp_b ? 8'hE1 : 8'h1E);
                if (n_ack > 0) begin
                    chk("contend_gap", i - last_ack, 3);
                    if (i - last_ack > 2 * 3) chk("starvation_bound", i - last_ack, 6);
                end
                last_ack = i; exp_b = !exp_b; n_ack++;
            end
        end
        chk("contend_ack_count", n_ack, 6);
        clear_reqs();
        step();
        step();

        // Three wait states on B, address 15.
        req_b[1] = 1; addr_b[1] = 4'd15;
        en_cnt = 0; first_en = -1; ack_at = -1; got = 8'h00;
        for (int i = 0; i < 15; i++) begin
            step();
            if (!rom_en_n[1]) begin
                en_cnt++;
                if (first_en < 0) first_en = i;
            end
            if (ack_b[1]) begin
                ack_at = i; got = data_out[1]; req_b[1] = 0;
            end
        end
        chk("ws3_en_cycles", en_cnt, 4);
        chk("ws3_ack_delay", ack_at - first_en, 4);
        chk("ws3_data", got, 8'hF0);

        // Full sweep 0..15 on port A, address changed in each ack cycle.
        req_a[0] = 1; addr_a[0] = 4'd0; idx = 0;
        for (int i = 0; i < 100 && idx < 16; i++) begin
            step();
            if (ack_a[0]) begin
                got = {4'(idx), ~4'(idx)};
                chk("sweep_data", data_out[0], got);
                chk("sweep_rom_addr", rom_addr[0], idx);
                idx++;
                if (idx < 16) addr_a[0] = 4'(idx);
                else req_a[0] = 0;
            end
        end
        chk("sweep_ack_count", idx, 16);
        req_a[0] = 0;
        step();
        step();

        // Async reset in the middle of a wait-state DRIVE on dut3.
        req_b[1] = 1; addr_b[1] = 4'd5;
        step();
        step();
        chk("pre_reset_en", rom_en_n[1], 0);
        #2;
        low_rst = 0;
        #1;
        chk("mid_reset_en", rom_en_n[1], 1);
        chk("mid_reset_busy", busy[1], 0);
        chk("mid_reset_data", data_out[1], 8'h00);
        step();
        step();
        low_rst = 1;
        n_ack = 0;
        for (int i = 0; i < 20 && n_ack == 0; i++) begin
            step();
            if (ack_a[1] || ack_b[1]) begin
                chk("post_reset_b_port", ack_b[1], 1);
                chk("post_reset_b_data", data_out[1], 8'h5A);
                n_ack++;
            end
        end
        chk("post_reset_b_served", n_ack, 1);
        clear_reqs();
        pulse_reset();
        req_a[1] = 1; addr_a[1] = 4'd2; req_b[1] = 1; addr_b[1] = 4'd9;
        n_ack = 0;
        for (int i = 0; i < 20 && n_ack == 0; i++) begin
            step();
            if (ack_a[1] || ack_b[1]) begin
                chk("post_reset_tie_a", ack_a[1], 1);
                chk("post_reset_tie_data", data_out[1], 8'h2D);
                n_ack++;
            end
        end
        chk("post_reset_tie_served", n_ack, 1);
        clear_reqs();
        step();
        step();

        // Randomized traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!low_rst) low_rst = 1;
            else if ($urandom_range(0, 599) == 0) low_rst = 0;
            for (int d = 0; d < 2; d++) begin
                if (ack_a[d]) begin
                    case ($urandom_range(0, 3))
                        0: req_a[d] = 0;
                        1: ;
                        default: addr_a[d] = 4'($urandom_range(0, 15));
                    endcase
                end else if (!req_a[d]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        req_a[d] = 1; addr_a[d] = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_a[d] = 0;
                end
                if (ack_b[d]) begin
                    case ($urandom_range(0, 3))
                        0: req_b[d] = 0;
                        1: ;
                        default: addr_b[d] = 4'($urandom_range(0, 15));
                    endcase
                end else if (!req_b[d]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        req_b[d] = 1; addr_b[d] = 4'($urandom_range(0, 15));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_b[d] = 0;
                end
            end
        end
        low_rst = 1;
        clear_reqs();
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
